alu_arbiter_seq: RTL and testbench

- Sequences the shared ALU datapath and its result/flag registers on behalf of two requesters: port 0 is the control matrix, port 1 is the debug/pin interface.
- Grants requests round-robin and drives the ALU operands and FuncOp from registered copies.
- Captures the ALU result and flags internally, then returns the result to the granted requester with a Done pulse.
- The ALU is external and combinational; this block replaces the hand-pulsed load strobes on the result/flag registers.

---
 rtl/alu_arbiter_seq_pkg.sv | 16 +
 rtl/alu_arbiter_seq_if.sv | 37 +++
 rtl/alu_arbiter_seq_rr_arbiter2.sv | 28 ++
 rtl/alu_arbiter_seq.sv | 101 ++++++++++
 tb/tb_alu_arbiter_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_seq_pkg.sv
// Shared types and constants for the ALU sequencer.
// State encoding and flag bit positions.
package alu_arbiter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_arbiter_seq_if.sv
// Requester-side bundle: two request ports with ack/done.
// master = requesters, slave = sequencer.
interface alu_arbiter_seq_if #(
  parameter int DataWidth = 16,
  parameter int OpWidth   = 4
);

  logic                 Req0;
  logic                 Req1;
  logic [OpWidth-1:0]   Op0;
  logic [OpWidth-1:0]   Op1;
  logic [DataWidth-1:0] A0;
  logic [DataWidth-1:0] A1;
  logic [DataWidth-1:0] B0;
  logic [DataWidth-1:0] B1;
  logic                 UpdF0;
  logic                 UpdF1;
  logic                 Ack0;
  logic                 Ack1;
  logic                 Done0;
  logic                 Done1;

  modport master (
    output Req0, Req1, Op0, Op1,
    output A0, A1, B0, B1,
    output UpdF0, UpdF1,
    input  Ack0, Ack1, Done0, Done1
  );

  modport slave (
    input  Req0, Req1, Op0, Op1,
    input  A0, A1, B0, B1,
    input  UpdF0, UpdF1,
    output Ack0, Ack1, Done0, Done1
  );

endinterface

// File: rtl/alu_arbiter_seq_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Pointer names the preferred port on a tie.
module alu_arbiter_seq_rr_arbiter2
  import alu_arbiter_seq_pkg::*;
(
  input  logic [1:0] Req,
  input  logic       Pointer,
  input  logic       Enable,
  output logic [1:0] Grant,
  output logic       Winner
);

  logic w_win;

  always_comb begin
    w_win = Req[1];
    if (&Req) w_win = Pointer;
  end

  always_comb begin
    Grant  = 2'b00;
    Winner = w_win;
    if (Enable && (|Req)) begin
      Grant = w_win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Sequences a shared combinational ALU for two requesters:
// IDLE grants, EXEC captures result/flags, WB signals done.
module alu_arbiter_seq
  import alu_arbiter_seq_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int FlagSize  = 4,
  parameter int OpWidth   = 4,
  parameter int CntWidth  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  alu_arbiter_seq_if.slave     bus,
  output logic [DataWidth-1:0] AluA,
  output logic [DataWidth-1:0] AluB,
  output logic [OpWidth-1:0]   AluOp,
  input  logic [DataWidth-1:0] AluY,
  input  logic [FlagSize-1:0]  AluFlags,
  output logic [DataWidth-1:0] Result,
  output logic [FlagSize-1:0]  Flags,
  input  logic                 ClrFlags,
  output logic                 Busy,
  output logic [CntWidth-1:0]  OpCount
);

  state_t     r_state;
  state_t     w_next;
  logic       r_ptr;
  logic       r_owner;
  logic       r_updf;
  logic [1:0] w_grant;
  logic       w_win;
  logic       w_idle;

  assign w_idle = (r_state == IDLE);

  alu_arbiter_seq_rr_arbiter2 u_arb (
    .Req     ({bus.Req1, bus.Req0}),
    .Pointer (r_ptr),
    .Enable  (w_idle),
    .Grant   (w_grant),
    .Winner  (w_win)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (|w_grant) w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ack is gated by Reset so nothing is acknowledged while held in reset.
  always_comb begin
    bus.Ack0  = w_grant[0] & Reset;
    bus.Ack1  = w_grant[1] & Reset;
    bus.Done0 = (r_state == WB) & ~r_owner;
    bus.Done1 = (r_state == WB) &  r_owner;
    Busy      = ~w_idle;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      AluA    <= '0;
      AluB    <= '0;
      AluOp   <= '0;
      r_owner <= 1'b0;
      r_updf  <= 1'b0;
      r_ptr   <= 1'b0;
    end else if (|w_grant) begin
      AluA    <= w_win ? bus.A1 : bus.A0;
      AluB    <= w_win ? bus.B1 : bus.B0;
      AluOp   <= w_win ? bus.Op1 : bus.Op0;
      r_owner <= w_win;
      r_updf  <= w_win ? bus.UpdF1 : bus.UpdF0;
      r_ptr   <= ~w_win;
    end
  end

  // Flag capture takes priority over a coincident clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Result  <= '0;
      Flags   <= '0;
      OpCount <= '0;
    end else begin
      if (r_state == EXEC) Result <= AluY;
      if ((r_state == EXEC) && r_updf) Flags <= AluFlags;
      else if (ClrFlags)               Flags <= '0;
      if (r_state == WB) OpCount <= OpCount + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a combinational ALU model.
// Vector table for single ops plus hand sequences for corner cases.
module tb_alu_arbiter_seq;
  import alu_arbiter_seq_pkg::*;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int OW = 4;
  localparam int CW = 2;

  logic          Clk;
  logic          Reset;
  logic [DW-1:0] AluA, AluB, AluY, Result;
  logic [OW-1:0] AluOp;
  logic [FW-1:0] AluFlags, Flags;
  logic          ClrFlags, Busy;
  logic [CW-1:0] OpCount;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt;

  alu_arbiter_seq_if #(.DataWidth(DW), .OpWidth(OW)) bus ();

  alu_arbiter_seq #(
    .DataWidth(DW), .FlagSize(FW),
    .OpWidth(OW), .CntWidth(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
    .AluY(AluY), .AluFlags(AluFlags),
    .Result(Result), .Flags(Flags),
    .ClrFlags(ClrFlags), .Busy(Busy),
    .OpCount(OpCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // op0 add, op1 sub, op2 and, op3 or, else xor; flags {V,N,C,Z}
  function automatic logic [19:0] alu_f(
    input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] y;
    logic        c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (y[15] != a[15]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        y = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (y[15] != a[15]);
      end
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      default: y = a ^ b;
    endcase
    return {v, y[15], c, (y == 16'd0), y};
  endfunction

  always_comb {AluFlags, AluY} = alu_f(AluOp, AluA, AluB);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        updf;
    logic [15:0] er;
    logic [3:0]  ef;
  } vec_t;

  vec_t vecs[7];

  task automatic clr_reqs();
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.port == 1'b0) begin
      bus.Req0 = 1'b1; bus.Op0 = v.op;
      bus.A0 = v.a; bus.B0 = v.b; bus.UpdF0 = v.updf;
    end else begin
      bus.Req1 = 1'b1; bus.Op1 = v.op;
      bus.A1 = v.a; bus.B1 = v.b; bus.UpdF1 = v.updf;
    end
    #1;
    chk("ack_own", v.port ? bus.Ack1 : bus.Ack0, 1);
    chk("ack_other", v.port ? bus.Ack0 : bus.Ack1, 0);
    @(posedge Clk); #1;
    clr_reqs();
    chk("busy_exec", Busy, 1);
    chk("done_exec", {bus.Done1, bus.Done0}, 0);
    chk("ack_exec", {bus.Ack1, bus.Ack0}, 0);
    chk("alu_a", AluA, v.a);
    chk("alu_b", AluB, v.b);
    chk("alu_op", AluOp, v.op);
    @(posedge Clk); #1;
    chk("done_wb", {bus.Done1, bus.Done0}, v.port ? 2'b10 : 2'b01);
    chk("busy_wb", Busy, 1);
    chk("result", Result, v.er);
    chk("flags", Flags, v.ef);
    @(posedge Clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    chk("busy_idle", Busy, 0);
    chk("done_idle", {bus.Done1, bus.Done0}, 0);
    chk("opcount", OpCount, exp_cnt);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd0, 16'h0012, 16'h0015, 1'b1, 16'h0027, 4'b0000};
    vecs[1] = '{1'b1, 4'd1, 16'h0012, 16'h0015, 1'b1, 16'hFFFD, 4'b0100};
    vecs[2] = '{1'b0, 4'd0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0100};
    vecs[3] = '{1'b1, 4'd2, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000};
    vecs[4] = '{1'b0, 4'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1100};
    vecs[5] = '{1'b1, 4'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 4'b0011};
    vecs[6] = '{1'b0, 4'd3, 16'h1200, 16'h0034, 1'b0, 16'h1234, 4'b0011};

    Reset = 1'b0; ClrFlags = 1'b0; exp_cnt = '0;
    clr_reqs();
    bus.Op0 = '0; bus.Op1 = '0; bus.A0 = '0; bus.A1 = '0;
    bus.B0 = '0; bus.B1 = '0; bus.UpdF0 = 1'b0; bus.UpdF1 = 1'b0;
    #1;
    chk("rst_alu", {AluA, AluB, AluOp}, 0);
    chk("rst_res", {Result, Flags}, 0);
    chk("rst_cnt", OpCount, 0);
    chk("rst_ctl", {Busy, bus.Ack1, bus.Ack0, bus.Done1, bus.Done0}, 0);
    #11 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("idle_nreq", {Busy, bus.Ack1, bus.Ack0}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    ClrFlags = 1'b1;
    @(posedge Clk); #1;
    ClrFlags = 1'b0;
    chk("clr_idle", Flags, 4'b0000);
    chk("clr_res_hold", Result, 16'h1234);

    // Clear during EXEC of a flag-updating op: capture must win.
    bus.Req0 = 1'b1; bus.Op0 = 4'd1; bus.A0 = 16'h0005;
    bus.B0 = 16'h0005; bus.UpdF0 = 1'b1;
    #1;
    chk("col_ack", bus.Ack0, 1);
    @(posedge Clk); #1;
    clr_reqs();
    ClrFlags = 1'b1;
    @(posedge Clk); #1;
    ClrFlags = 1'b0;
    chk("col_flags", Flags, 4'b0011);
    chk("col_done", bus.Done0, 1);
    @(posedge Clk); #1;
    exp_cnt = exp_cnt + 1'b1;
    chk("col_cnt", OpCount, exp_cnt);

    // Reset asserted mid-operation.
    bus.Req0 = 1'b1; bus.Op0 = 4'd0; bus.A0 = 16'h00AA;
    bus.B0 = 16'h0011; bus.UpdF0 = 1'b1;
    #1;
    @(posedge Clk); #1;
    chk("mid_exec", Busy, 1);
    bus.Req0 = 1'b0; bus.Req1 = 1'b1;
    Reset = 1'b0;
    #1;
    chk("mid_alu", {AluA, AluB, AluOp}, 0);
    chk("mid_res", {Result, Flags}, 0);
    chk("mid_cnt", OpCount, 0);
    chk("mid_ctl", {Busy, bus.Ack1, bus.Ack0, bus.Done1, bus.Done0}, 0);
    @(posedge Clk); #1;
    bus.Req1 = 1'b0;
    #3 Reset = 1'b1;
    exp_cnt = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk("mid_nodone", {Busy, bus.Done1, bus.Done0}, 0);
    end

    // Tie: both held; grants alternate 0,1,0,1 every 3 cycles.
    bus.Req0 = 1'b1; bus.Op0 = 4'd0; bus.A0 = 16'd1;
    bus.B0 = 16'd1; bus.UpdF0 = 1'b0;
    bus.Req1 = 1'b1; bus.Op1 = 4'd1; bus.A1 = 16'd10;
    bus.B1 = 16'd3; bus.UpdF1 = 1'b0;
    #1;
    for (int c = 0; c < 13; c++) begin
      int    n;
      logic  own;
      logic [1:0] ea, ed;
      n   = c / 3;
      own = n[0];
      ea  = ((c % 3 == 0) && (c < 12)) ? (own ? 2'b10 : 2'b01) : 2'b00;
      ed  = (c % 3 == 2) ? (own ? 2'b10 : 2'b01) : 2'b00;
      chk("tie_ack", {bus.Ack1, bus.Ack0}, ea);
      chk("tie_done", {bus.Done1, bus.Done0}, ed);
      if (c % 3 == 2)
        chk("tie_res", Result, own ? 16'd7 : 16'd2);
      if ((c % 3 == 0) && (c > 0)) begin
        exp_cnt = exp_cnt + 1'b1;
        chk("tie_cnt", OpCount, exp_cnt);
      end
      if (c == 11) clr_reqs();
      if (c < 12) begin
        @(posedge Clk); #1;
      end
    end
    chk("wrap_zero", OpCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
